// File: rtl/rvc_asap_cr_ctrl.sv
// rtl/rvc_asap_cr_ctrl.sv - memory-mapped control registers: 7-seg, LEDs, VGA cursor, switches, debounced buttons
module rvc_asap_cr_ctrl #(
  parameter logic [31:0] CR_BASE      = 32'h7000,
  parameter int          NUM_SEG7     = 6,
  parameter int          LED_W        = 10,
  parameter int          SW_W         = 10,
  parameter int          NUM_BTN      = 2,
  parameter bit          BTN_ACT_LOW  = 1'b1,
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic                  Clock,
  input  logic                  Rst_N,
  input  logic                  CrRdEn,
  input  logic                  CrWrEn,
  input  logic [31:0]           CrAddr,
  input  logic [3:0]            CrByteEn,
  input  logic [31:0]           CrWrData,
  output logic [31:0]           CrRdData,
  output logic                  CrIrq,
  input  logic [NUM_BTN-1:0]    Button,
  input  logic [SW_W-1:0]       Switch,
  output logic [8*NUM_SEG7-1:0] Seg7,
  output logic [LED_W-1:0]      Led,
  output logic [31:0]           CursorH,
  output logic [31:0]           CursorV
);

  localparam int OFF_LED    = NUM_SEG7;
  localparam int OFF_LEVEL  = NUM_SEG7 + 1;
  localparam int OFF_EVENT  = NUM_SEG7 + 2;
  localparam int OFF_IRQ_EN = NUM_SEG7 + 3;
  localparam int OFF_SWITCH = NUM_SEG7 + 4;
  localparam int OFF_CUR_H  = NUM_SEG7 + 5;
  localparam int OFF_CUR_V  = NUM_SEG7 + 6;
  localparam int MAP_WORDS  = NUM_SEG7 + 7;
  localparam int CW         = $clog2(DEBOUNCE_CYC) + 1;

  typedef enum logic {ST_STABLE, ST_COUNTING} db_state_t;

  logic [7:0]         seg7_q [NUM_SEG7];
  logic [LED_W-1:0]   led_q;
  logic [NUM_BTN-1:0] irq_en_q, event_q, level_q, level_d, btn_set, ev_clr;
  logic [31:0]        cur_h_q, cur_v_q, rd_data_q, rd_val, off;
  logic [31:0]        led_wr, cur_h_wr, cur_v_wr;
  logic [NUM_BTN-1:0] btn_norm, btn_sync1, btn_sync2;
  logic [SW_W-1:0]    sw_sync1, sw_sync2;
  logic               hit, wr_hit, irq_q;
  db_state_t          state_q [NUM_BTN];
  db_state_t          state_d [NUM_BTN];
  logic [CW-1:0]      cnt_q [NUM_BTN];
  logic [CW-1:0]      cnt_d [NUM_BTN];

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? wd[8*k +: 8] : old[8*k +: 8];
    return r;
  endfunction

  // Word offset relative to the region floor; anything outside the map or unaligned is a miss.
  assign off    = (CrAddr - CR_BASE) >> 2;
  assign hit    = (CrAddr >= CR_BASE) && (off < 32'(MAP_WORDS)) && (CrAddr[1:0] == 2'b00);
  assign wr_hit = CrWrEn && hit;

  assign led_wr   = merge_be(32'(led_q), CrWrData, CrByteEn);
  assign cur_h_wr = merge_be(cur_h_q, CrWrData, CrByteEn);
  assign cur_v_wr = merge_be(cur_v_q, CrWrData, CrByteEn);
  assign ev_clr   = (wr_hit && off == 32'(OFF_EVENT) && CrByteEn[0]) ? CrWrData[NUM_BTN-1:0] : '0;
  assign btn_norm = BTN_ACT_LOW ? ~Button : Button;

  for (genvar g = 0; g < NUM_SEG7; g++) begin : g_seg7
    assign Seg7[8*g +: 8] = seg7_q[g];
  end
  assign Led      = led_q;
  assign CursorH  = cur_h_q;
  assign CursorV  = cur_v_q;
  assign CrRdData = rd_data_q;
  assign CrIrq    = irq_q;

  // Software-writable registers; RO offsets simply have no write branch.
  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N) begin
      for (int i = 0; i < NUM_SEG7; i++) seg7_q[i] <= 8'hFF;
      led_q    <= '0;
      irq_en_q <= '0;
      cur_h_q  <= '0;
      cur_v_q  <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i < NUM_SEG7; i++)
        if (off == 32'(i) && CrByteEn[0]) seg7_q[i] <= CrWrData[7:0];
      if (off == 32'(OFF_LED)) led_q <= led_wr[LED_W-1:0];
      if (off == 32'(OFF_IRQ_EN) && CrByteEn[0]) irq_en_q <= CrWrData[NUM_BTN-1:0];
      if (off == 32'(OFF_CUR_H)) cur_h_q <= cur_h_wr;
      if (off == 32'(OFF_CUR_V)) cur_v_q <= cur_v_wr;
    end
  end

  // Sticky press events: a new rising level beats a coincident write-one-to-clear.
  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N) begin
      event_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      event_q <= (event_q & ~ev_clr) | btn_set;
      irq_q   <= |(event_q & irq_en_q);
    end
  end

  // Read mux from the pre-write register state; misses read as zero.
  always_comb begin
    rd_val = '0;
    if (hit) begin
      for (int i = 0; i < NUM_SEG7; i++)
        if (off == 32'(i)) rd_val = {24'd0, seg7_q[i]};
      if (off == 32'(OFF_LED))    rd_val = 32'(led_q);
      if (off == 32'(OFF_LEVEL))  rd_val = 32'(level_q);
      if (off == 32'(OFF_EVENT))  rd_val = 32'(event_q);
      if (off == 32'(OFF_IRQ_EN)) rd_val = 32'(irq_en_q);
      if (off == 32'(OFF_SWITCH)) rd_val = 32'(sw_sync2);
      if (off == 32'(OFF_CUR_H))  rd_val = cur_h_q;
      if (off == 32'(OFF_CUR_V))  rd_val = cur_v_q;
    end
  end

  // Read data register holds between reads.
  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N)      rd_data_q <= '0;
    else if (CrRdEn) rd_data_q <= rd_val;
  end

  // Two-flop synchronisers for the asynchronous pins.
  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N) begin
      btn_sync1 <= '0;
      btn_sync2 <= '0;
      sw_sync1  <= '0;
      sw_sync2  <= '0;
    end else begin
      btn_sync1 <= btn_norm;
      btn_sync2 <= btn_sync1;
      sw_sync1  <= Switch;
      sw_sync2  <= sw_sync1;
    end
  end

  // Debounce state, counters and accepted levels.
  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N) begin
      for (int b = 0; b < NUM_BTN; b++) begin
        state_q[b] <= ST_STABLE;
        cnt_q[b]   <= '0;
      end
      level_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BTN; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      level_q <= level_d;
    end
  end

  // Per-button debounce: a change is accepted after DEBOUNCE_CYC consecutive differing samples.
  always_comb begin
    level_d = level_q;
    btn_set = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      case (state_q[b])
        ST_STABLE: begin
          cnt_d[b] = '0;
          if (btn_sync2[b] != level_q[b]) begin
            state_d[b] = ST_COUNTING;
            cnt_d[b]   = CW'(1);
          end
        end
        ST_COUNTING: begin
          if (btn_sync2[b] == level_q[b]) begin
            state_d[b] = ST_STABLE;
            cnt_d[b]   = '0;
          end else if (cnt_q[b] == CW'(DEBOUNCE_CYC - 1)) begin
            state_d[b] = ST_STABLE;
            cnt_d[b]   = '0;
            level_d[b] = btn_sync2[b];
            btn_set[b] = btn_sync2[b];
          end else begin
            cnt_d[b] = cnt_q[b] + CW'(1);
          end
        end
        default: begin
          state_d[b] = ST_STABLE;
          cnt_d[b]   = '0;
        end
      endcase
    end
  end

endmodule
